// File: rtl/serv_bus_pkg.sv
// Shared definitions for the SERV bus scheduler: FSM states, owner
// encoding, one-hot grant constants and the timeout counter width helper.
package serv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_IBUS = 2'd1,
        ST_DBUS = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    // o_grant is {dbus, ibus}
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IBUS = 2'b01;
    localparam logic [1:0] GRANT_DBUS = 2'b10;

    // Counter width for a timeout of 'timeout' cycles; at least one bit so
    // the disabled (timeout == 0) build still elaborates.
    function automatic int timer_width(input int timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/serv_bus_timer.sv
// Per-transaction ack timer.
//   clk      in  clock
//   i_rst_n  in  asynchronous active-low reset
//   i_clr    in  synchronous clear (held while no transaction is owned)
//   i_en     in  count this cycle (a transaction is owned)
//   o_expire out high in the owned cycle where the count reaches TIMEOUT-1
// The counter saturates at all-ones rather than wrapping. With TIMEOUT == 0
// the expire output is tied low.
module serv_bus_timer
    import serv_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int W      = timer_width(TIMEOUT);
    localparam int LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [W-1:0] LAST = W'(LAST_I);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign o_expire = 1'b0;
        end else begin : g_timeout
            assign o_expire = i_en && (cnt == LAST);
        end
    endgenerate

endmodule

// File: rtl/serv_bus_scheduler.sv
// Shares one Wishbone memory port between the SERV instruction bus
// (read-only) and data bus.
//   clk, i_rst_n                  clock, asynchronous active-low reset
//   i_ibus_adr/cyc, o_ibus_rdt/ack  instruction fetch master
//   i_dbus_adr/dat/sel/we/cyc, o_dbus_rdt/ack  data master
//   o_mem_adr/dat/sel/we/cyc, i_mem_rdt/ack    shared slave port
//   i_clr_err, o_timeout          sticky timeout flag and its clear
//   o_grant                       {dbus,ibus} one-hot owner, 00 when idle
// Handshake: a master raises cyc and holds it until its one-cycle ack; the
// grant is taken from the registered state, so a request seen in IDLE is
// presented to the slave on the following cycle. Every completion (ack,
// abort or timeout) returns to IDLE for one cycle, which gives SERV time to
// drop cyc before the next grant. Ties in IDLE go to the master that did
// not own the port last.
module serv_bus_scheduler
    import serv_bus_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int TIMEOUT = 255,
    parameter logic [DW-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic            clk,
    input  logic            i_rst_n,
    input  logic [AW-1:0]   i_ibus_adr,
    input  logic            i_ibus_cyc,
    output logic [DW-1:0]   o_ibus_rdt,
    output logic            o_ibus_ack,
    input  logic [AW-1:0]   i_dbus_adr,
    input  logic [DW-1:0]   i_dbus_dat,
    input  logic [DW/8-1:0] i_dbus_sel,
    input  logic            i_dbus_we,
    input  logic            i_dbus_cyc,
    output logic [DW-1:0]   o_dbus_rdt,
    output logic            o_dbus_ack,
    output logic [AW-1:0]   o_mem_adr,
    output logic [DW-1:0]   o_mem_dat,
    output logic [DW/8-1:0] o_mem_sel,
    output logic            o_mem_we,
    output logic            o_mem_cyc,
    input  logic [DW-1:0]   i_mem_rdt,
    input  logic            i_mem_ack,
    input  logic            i_clr_err,
    output logic            o_timeout,
    output logic [1:0]      o_grant
);

    state_t state, state_nxt;
    owner_t last_owner, last_owner_nxt;

    logic owning;
    logic owner_cyc;
    logic timer_expire;
    logic to_fire;
    logic owner_ack;

    assign owning    = (state != ST_IDLE);
    assign owner_cyc = (state == ST_IBUS) ? i_ibus_cyc :
                       (state == ST_DBUS) ? i_dbus_cyc : 1'b0;

    // A slave ack in the expiry cycle wins over the timeout.
    assign to_fire   = owner_cyc && !i_mem_ack && timer_expire;
    assign owner_ack = owner_cyc && (i_mem_ack || to_fire);

    serv_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (!owning),
        .i_en     (owning),
        .o_expire (timer_expire)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            last_owner <= OWN_DBUS;
            o_timeout  <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            if (to_fire) begin
                o_timeout <= 1'b1;
            end else if (i_clr_err) begin
                o_timeout <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        o_grant        = GRANT_NONE;
        o_mem_adr      = '0;
        o_mem_dat      = '0;
        o_mem_sel      = '0;
        o_mem_we       = 1'b0;
        o_mem_cyc      = 1'b0;
        o_ibus_ack     = 1'b0;
        o_ibus_rdt     = '0;
        o_dbus_ack     = 1'b0;
        o_dbus_rdt     = '0;

        case (state)
            ST_IDLE: begin
                if (i_ibus_cyc && i_dbus_cyc) begin
                    state_nxt = (last_owner == OWN_DBUS) ? ST_IBUS : ST_DBUS;
                end else if (i_ibus_cyc) begin
                    state_nxt = ST_IBUS;
                end else if (i_dbus_cyc) begin
                    state_nxt = ST_DBUS;
                end
            end
            ST_IBUS: begin
                o_grant    = GRANT_IBUS;
                o_mem_adr  = i_ibus_adr;
                o_mem_sel  = '1;
                o_mem_cyc  = i_ibus_cyc && !to_fire;
                o_ibus_ack = owner_ack;
                o_ibus_rdt = to_fire ? ERR_DATA : i_mem_rdt;
                // Dropping cyc without an ack is an abort.
                if (!i_ibus_cyc || owner_ack) begin
                    state_nxt      = ST_IDLE;
                    last_owner_nxt = OWN_IBUS;
                end
            end
            ST_DBUS: begin
                o_grant    = GRANT_DBUS;
                o_mem_adr  = i_dbus_adr;
                o_mem_dat  = i_dbus_dat;
                o_mem_sel  = i_dbus_sel;
                o_mem_we   = i_dbus_we;
                o_mem_cyc  = i_dbus_cyc && !to_fire;
                o_dbus_ack = owner_ack;
                o_dbus_rdt = to_fire ? ERR_DATA : i_mem_rdt;
                if (!i_dbus_cyc || owner_ack) begin
                    state_nxt      = ST_IDLE;
                    last_owner_nxt = OWN_DBUS;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serv_bus_scheduler.sv
// Bench for serv_bus_scheduler with TIMEOUT=8: directed scenarios followed
// by random masters and slave, all checked against a transaction-level
// reference model every cycle.
module tb_serv_bus_scheduler;

    localparam int TO = 8;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_mem_adr;
    logic [31:0] o_mem_dat;
    logic [3:0]  o_mem_sel;
    logic        o_mem_we;
    logic        o_mem_cyc;
    logic [31:0] i_mem_rdt;
    logic        i_mem_ack;
    logic        i_clr_err;
    logic        o_timeout;
    logic [1:0]  o_grant;

    serv_bus_scheduler #(.AW(32), .DW(32), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_mem_adr  (o_mem_adr),
        .o_mem_dat  (o_mem_dat),
        .o_mem_sel  (o_mem_sel),
        .o_mem_we   (o_mem_we),
        .o_mem_cyc  (o_mem_cyc),
        .i_mem_rdt  (i_mem_rdt),
        .i_mem_ack  (i_mem_ack),
        .i_clr_err  (i_clr_err),
        .o_timeout  (o_timeout),
        .o_grant    (o_grant)
    );

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: who holds the port (0 none, 1 ibus, 2 dbus), who held
    // it last, how many cycles the current holder has had, sticky flag.
    int m_own, m_last, m_age;
    bit m_to;
    bit exp_iack, exp_dack;

    // Snapshot of DUT outputs from the most recent checked cycle.
    logic [1:0]  s_grant;
    logic        s_mem_cyc, s_mem_we, s_iack, s_dack, s_to;
    logic [3:0]  s_mem_sel;
    logic [31:0] s_mem_dat, s_irdt, s_drdt;

    task automatic model_reset();
        m_own = 0; m_last = 2; m_age = 0; m_to = 0;
        exp_iack = 0; exp_dack = 0;
    endtask

    task automatic idle_inputs();
        i_ibus_adr = '0; i_ibus_cyc = 0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 0; i_dbus_cyc = 0;
        i_mem_rdt = '0; i_mem_ack = 0; i_clr_err = 0;
    endtask

    // Compare all outputs against the model for the current inputs, then
    // move the model to the next cycle.
    task automatic check_cycle();
        logic [1:0]  e_grant;
        logic [31:0] e_adr, e_dat, e_irdt, e_drdt, rdt;
        logic [3:0]  e_sel;
        bit e_we, e_cyc, e_iack, e_dack, cyc, fire, ack;
        e_grant = 0; e_adr = 0; e_dat = 0; e_sel = 0; e_we = 0; e_cyc = 0;
        e_iack = 0; e_dack = 0; e_irdt = 0; e_drdt = 0; fire = 0; cyc = 0;
        if (m_own != 0) begin
            cyc  = (m_own == 1) ? i_ibus_cyc : i_dbus_cyc;
            fire = cyc && !i_mem_ack && (m_age == TO - 1);
            ack  = cyc && (i_mem_ack || fire);
            rdt  = fire ? ERR : i_mem_rdt;
            e_cyc = cyc && !fire;
            if (m_own == 1) begin
                e_grant = 2'b01; e_adr = i_ibus_adr; e_sel = 4'hF;
                e_iack = ack; e_irdt = rdt;
            end else begin
                e_grant = 2'b10; e_adr = i_dbus_adr; e_dat = i_dbus_dat;
                e_sel = i_dbus_sel; e_we = i_dbus_we;
                e_dack = ack; e_drdt = rdt;
            end
        end
        check("grant", o_grant, e_grant);
        check("mem_cyc", o_mem_cyc, e_cyc);
        check("mem_adr", o_mem_adr, e_adr);
        check("mem_dat", o_mem_dat, e_dat);
        check("mem_sel", o_mem_sel, e_sel);
        check("mem_we", o_mem_we, e_we);
        check("ibus_ack", o_ibus_ack, e_iack);
        check("ibus_rdt", o_ibus_rdt, e_irdt);
        check("dbus_ack", o_dbus_ack, e_dack);
        check("dbus_rdt", o_dbus_rdt, e_drdt);
        check("timeout", o_timeout, m_to);
        s_grant = o_grant; s_mem_cyc = o_mem_cyc; s_mem_we = o_mem_we;
        s_mem_sel = o_mem_sel; s_mem_dat = o_mem_dat; s_iack = o_ibus_ack;
        s_dack = o_dbus_ack; s_irdt = o_ibus_rdt; s_drdt = o_dbus_rdt; s_to = o_timeout;
        exp_iack = e_iack; exp_dack = e_dack;
        // advance
        if (fire) m_to = 1;
        else if (i_clr_err) m_to = 0;
        if (m_own == 0) begin
            m_age = 0;
            if (i_ibus_cyc && i_dbus_cyc) m_own = (m_last == 1) ? 2 : 1;
            else if (i_ibus_cyc) m_own = 1;
            else if (i_dbus_cyc) m_own = 2;
        end else if (!cyc || ack) begin
            m_last = m_own;
            m_own  = 0;
        end else begin
            m_age++;
        end
    endtask

    // Inputs are driven just after posedge; outputs checked at negedge.
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", o_grant, 2'b00);
        check("rst_timeout", o_timeout, 1'b0);
        check("rst_mem_cyc", o_mem_cyc, 1'b0);
        model_reset();
        i_rst_n = 1;
    endtask

    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int ack_pct;

    initial begin
        idle_inputs();
        model_reset();

        // Single ibus fetch, slave acks 3 cycles after cyc.
        do_reset();
        i_ibus_cyc = 1; i_ibus_adr = 32'h100;
        step();
        check("fetch_grant_c0", s_grant, 2'b00);
        step();
        check("fetch_grant_c1", s_grant, 2'b01);
        step();
        i_mem_ack = 1; i_mem_rdt = 32'hCAFE_0001;
        step();
        check("fetch_ack", s_iack, 1'b1);
        check("fetch_rdt", s_irdt, 32'hCAFE_0001);
        check("fetch_dack", s_dack, 1'b0);
        i_mem_ack = 0; i_ibus_cyc = 0;
        step();
        check("fetch_ack_once", s_iack, 1'b0);

        // Both masters always requesting: grants must alternate I,D,I,D...
        do_reset();
        i_ibus_cyc = 1; i_dbus_cyc = 1; i_dbus_adr = 32'h40; i_dbus_sel = 4'hF;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(2'b01);
            exp_q.push_back(2'b10);
        end
        for (int c = 0; c < 20; c++) begin
            i_mem_ack = (m_own != 0);
            i_mem_rdt = $urandom;
            step();
            if (s_grant != 2'b00) got_q.push_back(s_grant);
        end
        i_ibus_cyc = 0; i_dbus_cyc = 0; i_mem_ack = 0;
        step();
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check("rr_missing", 1'b0, 1'b1);
                exp_q.delete();
            end else begin
                check("rr_order", got_q.pop_front(), exp_q.pop_front());
            end
        end
        got_q.delete();

        // Dbus write.
        do_reset();
        i_dbus_cyc = 1; i_dbus_we = 1; i_dbus_adr = 32'h2000;
        i_dbus_dat = 32'h1234_5678; i_dbus_sel = 4'b0011;
        step();
        step();
        check("wr_we", s_mem_we, 1'b1);
        check("wr_sel", s_mem_sel, 4'b0011);
        check("wr_dat", s_mem_dat, 32'h1234_5678);
        i_mem_ack = 1;
        step();
        check("wr_dack", s_dack, 1'b1);
        check("wr_iack", s_iack, 1'b0);
        idle_inputs();
        step();

        // Timeout with a silent slave.
        do_reset();
        i_ibus_cyc = 1; i_ibus_adr = 32'h200;
        for (int c = 0; c < TO; c++) step();
        step();
        check("to_ack", s_iack, 1'b1);
        check("to_rdt", s_irdt, ERR);
        check("to_mem_cyc", s_mem_cyc, 1'b0);
        i_ibus_cyc = 0;
        step();
        check("to_flag", s_to, 1'b1);
        step();
        i_clr_err = 1;
        step();
        check("to_flag_held", s_to, 1'b1);
        i_clr_err = 0;
        i_dbus_cyc = 1; i_dbus_adr = 32'h300; i_dbus_sel = 4'hF;
        step();
        check("to_cleared", s_to, 1'b0);
        step();
        i_mem_ack = 1; i_mem_rdt = 32'h0BAD_F00D;
        step();
        check("after_to_dack", s_dack, 1'b1);
        check("after_to_rdt", s_drdt, 32'h0BAD_F00D);
        idle_inputs();
        step();

        // Ack arriving in the expiry cycle wins.
        do_reset();
        i_ibus_cyc = 1; i_ibus_adr = 32'h400;
        for (int c = 0; c < TO; c++) step();
        i_mem_ack = 1; i_mem_rdt = 32'h55AA_55AA;
        step();
        check("exp_ack", s_iack, 1'b1);
        check("exp_rdt", s_irdt, 32'h55AA_55AA);
        idle_inputs();
        step();
        check("exp_no_flag", s_to, 1'b0);

        // Owner drops cyc mid-wait.
        do_reset();
        i_dbus_cyc = 1; i_dbus_adr = 32'h500;
        repeat (4) step();
        i_dbus_cyc = 0;
        step();
        check("abort_no_ack", s_dack, 1'b0);
        step();
        check("abort_idle", s_grant, 2'b00);

        // Reset while dbus owns the port.
        do_reset();
        i_dbus_cyc = 1; i_dbus_adr = 32'h600; i_dbus_sel = 4'hF;
        step();
        step();
        check("pre_rst_grant", s_grant, 2'b10);
        #2;
        i_rst_n = 0;
        #1;
        check("mid_rst_mem_cyc", o_mem_cyc, 1'b0);
        check("mid_rst_dack", o_dbus_ack, 1'b0);
        check("mid_rst_grant", o_grant, 2'b00);
        model_reset();
        i_ibus_cyc = 1;
        @(posedge clk);
        #1;
        i_rst_n = 1;
        step();
        step();
        check("post_rst_tie", s_grant, 2'b01);
        idle_inputs();
        step();
        step();

        // Random masters and slave.
        do_reset();
        ack_pct = 40;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 0;
                    1: ack_pct = 10;
                    2: ack_pct = 40;
                    default: ack_pct = 90;
                endcase
            end
            if (i_ibus_cyc) begin
                if (exp_iack || $urandom_range(0, 99) < 2) i_ibus_cyc = 0;
            end else if ($urandom_range(0, 99) < 40) begin
                i_ibus_cyc = 1;
                i_ibus_adr = $urandom & 32'hFFFF_FFFC;
            end
            if (i_dbus_cyc) begin
                if (exp_dack || $urandom_range(0, 99) < 2) i_dbus_cyc = 0;
            end else if ($urandom_range(0, 99) < 40) begin
                i_dbus_cyc = 1;
                i_dbus_adr = $urandom;
                i_dbus_dat = $urandom;
                i_dbus_sel = 4'($urandom_range(0, 15));
                i_dbus_we  = 1'($urandom_range(0, 1));
            end
            i_mem_ack = ($urandom_range(0, 99) < ack_pct);
            i_mem_rdt = $urandom;
            i_clr_err = ($urandom_range(0, 99) < 5);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
